// File: rtl/pong_btn_conditioner.sv
// Push-button conditioner: 2-FF sync, counter debounce, 4-state FSM, press/release strobes.
// Define BTN_AUTOREPEAT_EN to add held-button auto-repeat press strobes.

module pong_btn_channel #(
  parameter int DEB_CYC    = 650000,
  parameter int RPT_DELAY  = 26000000,
  parameter int RPT_PERIOD = 6500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic s,
  output logic level,
  output logic press,
  output logic release_o
);
  localparam int MAX_A = (DEB_CYC > RPT_DELAY) ? DEB_CYC : RPT_DELAY;
  localparam int MAX_C = (MAX_A > RPT_PERIOD) ? MAX_A : RPT_PERIOD;
  localparam int CW    = (MAX_C < 1) ? 1 : $clog2(MAX_C + 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYC - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_RELEASE} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx, cnt_inc;
  logic          press_nx, rel_nx;

  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CW-1:0] RPT_D_LAST = CW'(RPT_DELAY - 1);
  localparam logic [CW-1:0] RPT_P_LAST = CW'(RPT_PERIOD - 1);
  logic [CW-1:0] rpt, rpt_nx, rpt_inc;
  logic          rpt_first, rpt_first_nx, rpt_hit;

  assign rpt_inc = (rpt == CNT_MAX) ? rpt : rpt + 1'b1;
  assign rpt_hit = (rpt == (rpt_first ? RPT_D_LAST : RPT_P_LAST));
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    press_nx = 1'b0;
    rel_nx   = 1'b0;
    case (state)
      IDLE: if (s) begin
        state_nx = DEB_PRESS;
        cnt_nx   = '0;
      end
      DEB_PRESS: begin
        if (!s) state_nx = IDLE;
        else if (cnt == DEB_LAST) begin
          state_nx = HELD;
          press_nx = 1'b1;
        end else cnt_nx = cnt_inc;
      end
      HELD: if (!s) begin
        state_nx = DEB_RELEASE;
        cnt_nx   = '0;
      end
      DEB_RELEASE: begin
        if (s) state_nx = HELD;
        else if (cnt == DEB_LAST) begin
          state_nx = IDLE;
          rel_nx   = 1'b1;
        end else cnt_nx = cnt_inc;
      end
      default: state_nx = IDLE;
    endcase
`ifdef BTN_AUTOREPEAT_EN
    rpt_nx       = rpt;
    rpt_first_nx = rpt_first;
    if (press_nx) begin
      rpt_nx       = '0;
      rpt_first_nx = 1'b1;
    end else if (state == HELD || state == DEB_RELEASE) begin
      // an accepted release suppresses a repeat due in the same cycle
      if (rel_nx) begin
        rpt_nx       = '0;
        rpt_first_nx = 1'b1;
      end else if (rpt_hit) begin
        press_nx     = 1'b1;
        rpt_nx       = '0;
        rpt_first_nx = 1'b0;
      end else rpt_nx = rpt_inc;
    end else begin
      rpt_nx       = '0;
      rpt_first_nx = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      press     <= 1'b0;
      release_o <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rpt       <= '0;
      rpt_first <= 1'b1;
`endif
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      press     <= press_nx;
      release_o <= rel_nx;
`ifdef BTN_AUTOREPEAT_EN
      rpt       <= rpt_nx;
      rpt_first <= rpt_first_nx;
`endif
    end
  end

  assign level = (state == HELD) || (state == DEB_RELEASE);
endmodule

module pong_btn_conditioner #(
  parameter int N_BTN      = 3,
  parameter int DEB_CYC    = 650000,
  parameter int RPT_DELAY  = 26000000,
  parameter int RPT_PERIOD = 6500000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);
  logic [1:0][N_BTN-1:0] sync_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_pipe <= '0;
    else        sync_pipe <= {sync_pipe[0], btn_raw};
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    pong_btn_channel #(
      .DEB_CYC   (DEB_CYC),
      .RPT_DELAY (RPT_DELAY),
      .RPT_PERIOD(RPT_PERIOD)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .s        (sync_pipe[1][i]),
      .level    (btn_level[i]),
      .press    (btn_press[i]),
      .release_o(btn_release[i])
    );
  end
endmodule
